dct_io_adapter: RTL



---
 rtl/dct_io_adapter_pkg.sv | 22 ++
 rtl/dct_io_adapter_pin_serializer.sv | 78 +++++++
 rtl/dct_io_adapter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dct_io_adapter_pkg.sv
// rtl/dct_io_adapter_pkg.sv - shared state, mode encodings and helpers for the DCT pad adapter
package dct_io_pkg;

   // Block-level sequencing: collect samples, launch core, wait, load bypass data, stream out
   typedef enum logic [2:0] {
      ST_FILL  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LOAD  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   // Codes 2 and 3 on the mode pins behave as DCT and are folded to MODE_DCT when latched
   localparam logic [1:0] MODE_DCT = 2'd0;
   localparam logic [1:0] MODE_BYP = 2'd1;

   // Number of pin beats needed to carry one coefficient
   function automatic int beats(input int out_w, input int pin_w);
      return out_w / pin_w;
   endfunction

endpackage

// File: rtl/dct_io_adapter_pin_serializer.sv
// rtl/dct_io_adapter_pin_serializer.sv - streams an N-coefficient buffer off-chip PIN_W bits per beat
module pin_serializer
   import dct_io_pkg::*;
#(
   parameter int N     = 8,
   parameter int OUT_W = 12,
   parameter int PIN_W = 4
)
(
   input  logic               clk,
   input  logic               rstn,
   input  logic               load,
   input  logic [N*OUT_W-1:0] data,
   output logic [PIN_W-1:0]   pin_out,
   output logic               pin_out_vld,
   output logic               pin_out_sof,
   output logic               done
);

   localparam int BEATS  = beats(OUT_W, PIN_W);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int COEF_W = $clog2(N);

   logic [N*OUT_W-1:0] obuf;
   logic [BEAT_W-1:0]  beat;
   logic [COEF_W-1:0]  coef;
   logic [BEAT_W-1:0]  next_beat;
   logic [COEF_W-1:0]  next_coef;
   logic               last;

   // The beat currently on the pins is the final chunk of the final coefficient
   assign last = (beat == BEAT_W'(BEATS - 1)) && (coef == COEF_W'(N - 1));

   // Combinational so the parent can leave DRAIN on the very edge that retires the last beat
   assign done = pin_out_vld && last;

   // Position of the following beat: chunks of a coefficient LSB-first, then the next coefficient
   always_comb begin
      next_beat = beat + 1'b1;
      next_coef = coef;
      if (beat == BEAT_W'(BEATS - 1)) begin
         next_beat = '0;
         next_coef = coef + 1'b1;
      end
   end

   // Beat 0 goes out on the load edge itself; later beats follow with no gaps
   always_ff @(posedge clk) begin
      if (!rstn) begin
         obuf        <= '0;
         beat        <= '0;
         coef        <= '0;
         pin_out     <= '0;
         pin_out_vld <= 1'b0;
         pin_out_sof <= 1'b0;
      end else if (load) begin
         obuf        <= data;
         beat        <= '0;
         coef        <= '0;
         pin_out     <= data[PIN_W-1:0];
         pin_out_vld <= 1'b1;
         pin_out_sof <= 1'b1;
      end else if (pin_out_vld) begin
         pin_out_sof <= 1'b0;
         if (last) begin
            beat        <= '0;
            coef        <= '0;
            pin_out     <= '0;
            pin_out_vld <= 1'b0;
         end else begin
            beat    <= next_beat;
            coef    <= next_coef;
            pin_out <= obuf[int'(next_coef)*OUT_W + int'(next_beat)*PIN_W +: PIN_W];
         end
      end
   end

endmodule

// File: rtl/dct_io_adapter.sv
// rtl/dct_io_adapter.sv - pad-side framing between input pins, the 1-D DCT core and the output pins
module dct_io_adapter
   import dct_io_pkg::*;
#(
   parameter int N       = 8,
   parameter int IN_W    = 8,
   parameter int OUT_W   = 12,
   parameter int PIN_W   = 4,
   parameter int TIMEOUT = 64
)
(
   input  logic               clk,
   input  logic               rstn,
   input  logic [1:0]         mode,
   input  logic [IN_W-1:0]    pin_in,
   input  logic               pin_in_vld,
   output logic               pin_busy,
   output logic [N*IN_W-1:0]  core_in,
   output logic               core_start,
   input  logic               core_done,
   input  logic [N*OUT_W-1:0] core_out,
   output logic [PIN_W-1:0]   pin_out,
   output logic               pin_out_vld,
   output logic               pin_out_sof,
   output logic               err_drop,
   output logic               err_tmo
);

   localparam int CNT_W = $clog2(N);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [TMO_W-1:0]   tmo;
   logic [1:0]         mode_q;
   logic               ser_load;
   logic               ser_done;
   logic [N*OUT_W-1:0] load_data;

   // Output buffer is written either from the core result or, in bypass, from the raw samples
   assign ser_load = (state == ST_LOAD) || ((state == ST_WAIT) && core_done);

   // Bypass coefficients are the collected samples zero-extended to coefficient width
   always_comb begin
      load_data = core_out;
      if (state == ST_LOAD) begin
         for (int k = 0; k < N; k++) begin
            load_data[k*OUT_W +: OUT_W] = OUT_W'(core_in[k*IN_W +: IN_W]);
         end
      end
   end

   // Block sequencing, sample collection, timeout guard and sticky error flags
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= ST_FILL;
         cnt        <= '0;
         tmo        <= '0;
         mode_q     <= MODE_DCT;
         core_in    <= '0;
         core_start <= 1'b0;
         pin_busy   <= 1'b0;
         err_drop   <= 1'b0;
         err_tmo    <= 1'b0;
      end else begin
         core_start <= 1'b0;
         if (pin_in_vld && pin_busy) begin
            err_drop <= 1'b1;
         end
         case (state)
            ST_FILL: begin
               if (pin_in_vld) begin
                  core_in[int'(cnt)*IN_W +: IN_W] <= pin_in;
                  if (cnt == '0) begin
                     mode_q <= (mode == MODE_BYP) ? MODE_BYP : MODE_DCT;
                  end
                  if (cnt == CNT_W'(N - 1)) begin
                     cnt      <= '0;
                     pin_busy <= 1'b1;
                     if (mode_q == MODE_BYP) begin
                        state <= ST_LOAD;
                     end else begin
                        state      <= ST_START;
                        core_start <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_START: begin
               tmo   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // tmo holds the number of completed WAIT cycles; done beats a coincident timeout
               if (core_done) begin
                  state <= ST_DRAIN;
               end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                  err_tmo  <= 1'b1;
                  pin_busy <= 1'b0;
                  state    <= ST_FILL;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            ST_LOAD: begin
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (ser_done) begin
                  pin_busy <= 1'b0;
                  state    <= ST_FILL;
               end
            end
            default: begin
               state    <= ST_FILL;
               pin_busy <= 1'b0;
            end
         endcase
      end
   end

   pin_serializer #(
      .N     (N),
      .OUT_W (OUT_W),
      .PIN_W (PIN_W)
   ) u_ser (
      .clk         (clk),
      .rstn        (rstn),
      .load        (ser_load),
      .data        (load_data),
      .pin_out     (pin_out),
      .pin_out_vld (pin_out_vld),
      .pin_out_sof (pin_out_sof),
      .done        (ser_done)
   );

endmodule
